pixel_colorizer: RTL
====================

// Module: pixel_colorizer
// PURPOSE
//  Stage directly downstream of the per-pixel shape selector. Takes its
//  {black, id, multiple} result plus display sync sideband and emits the RGB
//  value the VGA output stage drives. Shape colours come from a small
//  writable palette. Overlapping shapes get a distinct highlight colour.
//  2-cycle fixed-latency pipeline, no backpressure (pixel-clock stream).
// PARAMETERS
//  MAXSHP        16           number of shapes / palette entries
//  COLOR_W       12           RGB width (RGB444)
//  OVERLAP_COLOR 12'hF00      colour for pixels covered by >1 shape
//  BG_COLOR      12'h000      colour for uncovered (black) pixels
//  BLINK_DIV     25_000_000   half-period, in clk cycles, of overlap blink
// PORTS
//  clk          in   1             pixel clock
//  rst          in   1             async, active-high reset
//  in_valid     in   1             in_* carries a pixel this cycle
//  in_black     in   1             no shape covers pixel
//  in_id        in   `INT_BITS     covering shape index
//  in_multiple  in   1             >1 shape covers pixel
//  in_hsync     in   1             sideband; delayed with the pixel
//  in_vsync     in   1             sideband; delayed with the pixel
//  in_de        in   1             display enable; delayed with the pixel
//  pal_we       in   1             palette write strobe
//  pal_addr     in   $clog2(MAXSHP) palette entry to write
//  pal_data     in   COLOR_W       palette write data
//  out_valid    out  1             in_valid delayed 2 cycles
//  out_rgb      out  COLOR_W       final pixel colour
//  out_hsync    out  1             in_hsync delayed 2 cycles
//  out_vsync    out  1             in_vsync delayed 2 cycles
//  out_de       out  1             in_de delayed 2 cycles
// BEHAVIOUR
//  - Reset (async, rst=1): every pipeline register 0; out_valid, out_rgb,
//    out_hsync, out_vsync, out_de = 0; all palette entries = {COLOR_W{1'b1}}.
//  - S1 (cycle n+1): register black/multiple/sideband/valid; read
//    palette[in_id] into a colour register. in_id >= MAXSHP reads BG_COLOR.
//  - S2 (cycle n+2): out_rgb =
//    !valid1 || !de1 -> 0; black1 -> BG_COLOR; multiple1 (ovl phase) ->
//    OVERLAP_COLOR; else palette colour from S1.
//    black1 overrides multiple1.
//  - Latency exactly 2 for rgb and all sideband. Bubbles (in_valid=0) pass
//    through as out_valid=0 with rgb 0. Sideband is still delayed unchanged.
//  - Palette write: takes effect at the clk edge with pal_we=1.
//    A same-cycle read of the same address returns the OLD value.
//    pal_addr >= MAXSHP: write ignored.
//  - Reset mid-frame: pipeline flushes to zeros. Next accepted pixel
//    appears 2 cycles after rst falls. Palette returns to white.
// CONFIGURATION
//  OVERLAP_BLINK_EN defined:
//  - Free-running counter 0..BLINK_DIV-1. At wrap it toggles a phase bit.
//    Counter and phase reset to 0.
//  - Phase 0: overlap pixels use OVERLAP_COLOR.
//  - Phase 1: overlap pixels use the palette colour of id.
//  - Phase is sampled at S2.
//  OVERLAP_BLINK_EN undefined:
//  - Counter and phase logic absent; overlap pixels always OVERLAP_COLOR.
// TESTING
//  - Reset, then pixel id=3, black=0, multiple=0, de=1 -> 2 cycles later
//    out_valid=1, out_rgb=12'hFFF.
//  - pal_we with addr 3, data 12'h0A5; next cycle pixel id=3 -> out_rgb=12'h0A5.
//    Read in the same cycle as the write -> 12'hFFF.
//  - black=1, multiple=1 -> 12'h000. black=0, multiple=1 (no blink) -> 12'hF00.
//  - Stream of 8 pixels with valid bubbles at 2 and 5 -> outputs match the
//    input order at +2 cycles. hsync/vsync/de match input delayed 2.
//  - Blink build, BLINK_DIV=4, overlap pixel held -> rgb alternates 12'hF00
//    and the palette colour every 4 cycles.
//  - Assert rst mid-stream -> all outputs 0 immediately (async). Palette reads
//    12'hFFF after release.

Source files
------------

// File: rtl/pixel_colorizer.sv
// ---------------------------------------------------------------------------
// pixel_colorizer
//   Turns the per-pixel shape-selector result {black, id, multiple} into the
//   RGB value for the VGA output stage. Shape colours come from a writable
//   palette; pixels covered by more than one shape get a highlight colour.
//   Fixed 2-cycle latency for rgb and all sync sideband, no backpressure.
//
// Optional feature (macro OVERLAP_BLINK_EN):
//   When defined, overlap pixels blink between OVERLAP_COLOR and the
//   palette colour of their id, with a half-period of BLINK_DIV clocks.
//   When undefined, overlap pixels are always OVERLAP_COLOR.
//
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   in_valid/in_black/in_id/in_multiple   selector result for this pixel
//   in_hsync/in_vsync/in_de  sync sideband, delayed with the pixel
//   pal_we/pal_addr/pal_data palette write port (out-of-range addr ignored)
//   out_valid/out_rgb        pixel colour, 2 cycles after input
//   out_hsync/out_vsync/out_de  sideband, 2 cycles after input
// ---------------------------------------------------------------------------
`ifndef INT_BITS
`define INT_BITS 4
`endif

module pixel_colorizer #(
    parameter int unsigned        MAXSHP        = 16,
    parameter int unsigned        COLOR_W       = 12,
    parameter logic [COLOR_W-1:0] OVERLAP_COLOR = 12'hF00,
    parameter logic [COLOR_W-1:0] BG_COLOR      = 12'h000,
    parameter int unsigned        BLINK_DIV     = 25_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_black,
    input  logic [`INT_BITS-1:0]        in_id,
    input  logic                        in_multiple,
    input  logic                        in_hsync,
    input  logic                        in_vsync,
    input  logic                        in_de,
    input  logic                        pal_we,
    input  logic [$clog2(MAXSHP)-1:0]   pal_addr,
    input  logic [COLOR_W-1:0]          pal_data,
    output logic                        out_valid,
    output logic [COLOR_W-1:0]          out_rgb,
    output logic                        out_hsync,
    output logic                        out_vsync,
    output logic                        out_de
);

    localparam int unsigned AW = $clog2(MAXSHP);
    localparam int unsigned IW = `INT_BITS;

    if (BLINK_DIV < 1) begin : g_bad_div
        $error("pixel_colorizer: BLINK_DIV must be at least 1");
    end

    // Range checks only exist when the index width can exceed the palette.
    logic addr_ok;
    logic id_ok;

    if ((1 << AW) > MAXSHP) begin : g_addr_chk
        assign addr_ok = (32'(pal_addr) < MAXSHP);
    end else begin : g_addr_full
        assign addr_ok = 1'b1;
    end

    if ((1 << IW) > MAXSHP) begin : g_id_chk
        assign id_ok = (32'(in_id) < MAXSHP);
    end else begin : g_id_full
        assign id_ok = 1'b1;
    end

    logic [AW-1:0] rd_idx;
    assign rd_idx = AW'(in_id);

    // Palette: registered write, so a read on the write edge sees old data.
    logic [COLOR_W-1:0] pal [MAXSHP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAXSHP; i++) begin
                pal[i] <= '1;
            end
        end else if (pal_we && addr_ok) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // Stage 1
    logic               v1, b1, m1, hs1, vs1, de1;
    logic [COLOR_W-1:0] col1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            b1   <= 1'b0;
            m1   <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            de1  <= 1'b0;
            col1 <= '0;
        end else begin
            v1   <= in_valid;
            b1   <= in_black;
            m1   <= in_multiple;
            hs1  <= in_hsync;
            vs1  <= in_vsync;
            de1  <= in_de;
            col1 <= id_ok ? pal[rd_idx] : BG_COLOR;
        end
    end

    // Overlap blink phase
    logic ovl_phase;

`ifdef OVERLAP_BLINK_EN
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [CW-1:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            ovl_phase <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            ovl_phase <= ~ovl_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign ovl_phase = 1'b0;
`endif

    // Stage 2: black wins over multiple; bubbles and blanking give 0.
    logic [COLOR_W-1:0] rgb_next;

    always_comb begin
        rgb_next = '0;
        if (v1 && de1) begin
            if (b1) begin
                rgb_next = BG_COLOR;
            end else if (m1 && !ovl_phase) begin
                rgb_next = OVERLAP_COLOR;
            end else begin
                rgb_next = col1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
        end else begin
            out_valid <= v1;
            out_rgb   <= rgb_next;
            out_hsync <= hs1;
            out_vsync <= vs1;
            out_de    <= de1;
        end
    end

endmodule
